// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART register-command parser.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    DO_WRITE,
    DO_READ,
    WAIT_READ,
    RESP
  } state_t;

  localparam logic [7:0] RESP_OK       = 8'h4B;
  localparam logic [7:0] RESP_ERR      = 8'h3F;
  localparam logic [7:0] DEF_CMD_WRITE = 8'h57;
  localparam logic [7:0] DEF_CMD_READ  = 8'h52;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte stream in, response byte out, and the simple register bus of the command parser.
interface uart_cmd_parser_if;

  logic [7:0] in_data_i;
  logic       in_valid_i;
  logic [7:0] out_data_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [7:0] reg_addr_o;
  logic [7:0] reg_wdata_o;
  logic       reg_write_o;
  logic       reg_read_o;
  logic [7:0] reg_rdata_i;
  logic       err_timeout_o;
  logic       err_overrun_o;

  modport slave (
    input  in_data_i, in_valid_i, out_ready_i, reg_rdata_i,
    output out_data_o, out_valid_o, reg_addr_o, reg_wdata_o,
    output reg_write_o, reg_read_o, err_timeout_o, err_overrun_o
  );

  modport master (
    output in_data_i, in_valid_i, out_ready_i, reg_rdata_i,
    input  out_data_o, out_valid_o, reg_addr_o, reg_wdata_o,
    input  reg_write_o, reg_read_o, err_timeout_o, err_overrun_o
  );

endinterface

// File: rtl/timeout_counter.sv
// Saturating idle-gap counter: clear restarts it, enable counts, expired marks the limit edge.
module timeout_counter #(
  parameter int LIMIT = 1200000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] FULL = W'(LIMIT);

  logic [W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != FULL)) begin
      count <= count + W'(1);
    end
  end

  // High in the cycle whose increment reaches LIMIT, so the owner can act on that same edge.
  assign expired = enable && (count >= LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes W/R register commands from the received byte stream and returns one response byte each.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1200000,
  parameter logic [7:0] CMD_WRITE      = DEF_CMD_WRITE,
  parameter logic [7:0] CMD_READ       = DEF_CMD_READ
) (
  input logic              clock,
  input logic              reset,
  uart_cmd_parser_if.slave bus
);

  state_t     state, state_next;
  logic [7:0] out_data, out_data_next;
  logic [7:0] reg_addr, reg_addr_next;
  logic [7:0] reg_wdata, reg_wdata_next;
  logic       is_write, is_write_next;
  logic       err_timeout, err_timeout_next;
  logic       err_overrun, err_overrun_next;
  logic       gap_en;
  logic       expired;

  assign gap_en = (state == GET_ADDR) || (state == GET_DATA);

  timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_gap (
    .clock   (clock),
    .reset   (reset),
    .clear   (bus.in_valid_i),
    .enable  (gap_en),
    .expired (expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      out_data    <= '0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      is_write    <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_next;
      out_data    <= out_data_next;
      reg_addr    <= reg_addr_next;
      reg_wdata   <= reg_wdata_next;
      is_write    <= is_write_next;
      err_timeout <= err_timeout_next;
      err_overrun <= err_overrun_next;
    end
  end

  always_comb begin
    state_next       = state;
    out_data_next    = out_data;
    reg_addr_next    = reg_addr;
    reg_wdata_next   = reg_wdata;
    is_write_next    = is_write;
    err_timeout_next = 1'b0;
    err_overrun_next = err_overrun;
    case (state)
      IDLE: begin
        if (bus.in_valid_i) begin
          if (bus.in_data_i == CMD_WRITE) begin
            is_write_next = 1'b1;
            state_next    = GET_ADDR;
          end else if (bus.in_data_i == CMD_READ) begin
            is_write_next = 1'b0;
            state_next    = GET_ADDR;
          end else begin
            out_data_next = RESP_ERR;
            state_next    = RESP;
          end
        end
      end
      // A byte on the expiry edge takes priority over the timeout.
      GET_ADDR: begin
        if (bus.in_valid_i) begin
          reg_addr_next = bus.in_data_i;
          state_next    = is_write ? GET_DATA : DO_READ;
        end else if (expired) begin
          err_timeout_next = 1'b1;
          state_next       = IDLE;
        end
      end
      GET_DATA: begin
        if (bus.in_valid_i) begin
          reg_wdata_next = bus.in_data_i;
          state_next     = DO_WRITE;
        end else if (expired) begin
          err_timeout_next = 1'b1;
          state_next       = IDLE;
        end
      end
      DO_WRITE: begin
        out_data_next = RESP_OK;
        state_next    = RESP;
      end
      DO_READ:   state_next = WAIT_READ;
      WAIT_READ: begin
        out_data_next = bus.reg_rdata_i;
        state_next    = RESP;
      end
      RESP: begin
        if (bus.out_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (bus.in_valid_i && ((state == DO_WRITE) || (state == DO_READ) ||
                           (state == WAIT_READ) || (state == RESP))) begin
      err_overrun_next = 1'b1;
    end
  end

  assign bus.out_data_o    = out_data;
  assign bus.out_valid_o   = (state == RESP);
  assign bus.reg_addr_o    = reg_addr;
  assign bus.reg_wdata_o   = reg_wdata;
  assign bus.reg_write_o   = (state == DO_WRITE);
  assign bus.reg_read_o    = (state == DO_READ);
  assign bus.err_timeout_o = err_timeout;
  assign bus.err_overrun_o = err_overrun;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: one instance at the default timeout, one at a 100-cycle timeout.
module tb_uart_cmd_parser;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] rdata = 8'hEE;
  logic [7:0] rd_val = 8'h00;

  int checks = 0;
  int failures = 0;

  int wr_a = 0, xf_a = 0;
  int wr_b = 0, rd_b = 0, xf_b = 0, to_b = 0, both_b = 0;
  logic [7:0] last_a = 8'h00, last_b = 8'h00;

  uart_cmd_parser_if bus_a();
  uart_cmd_parser_if bus_b();

  assign bus_a.in_data_i   = in_data;
  assign bus_a.in_valid_i  = in_valid;
  assign bus_a.out_ready_i = out_ready;
  assign bus_a.reg_rdata_i = rdata;
  assign bus_b.in_data_i   = in_data;
  assign bus_b.in_valid_i  = in_valid;
  assign bus_b.out_ready_i = out_ready;
  assign bus_b.reg_rdata_i = rdata;

  uart_cmd_parser dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  uart_cmd_parser #(.TIMEOUT_CYCLES(100)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clock = ~clock;

  // Register file stand-in: read data is valid only in the cycle after reg_read_o.
  always @(posedge clock) rdata <= bus_b.reg_read_o ? rd_val : 8'hEE;

  always @(negedge clock) begin
    if (bus_a.reg_write_o) wr_a++;
    if (bus_a.out_valid_o && bus_a.out_ready_i) begin
      xf_a++;
      last_a = bus_a.out_data_o;
    end
    if (bus_b.reg_write_o) wr_b++;
    if (bus_b.reg_read_o) rd_b++;
    if (bus_b.reg_write_o && bus_b.reg_read_o) both_b++;
    if (bus_b.err_timeout_o) to_b++;
    if (bus_b.out_valid_o && bus_b.out_ready_i) begin
      xf_b++;
      last_b = bus_b.out_data_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, r0, x0, t0;
    logic stable;

    // Reset values
    #1;
    check("rst_out_valid", 32'(bus_b.out_valid_o), 0);
    check("rst_out_data", 32'(bus_b.out_data_o), 0);
    check("rst_addr", 32'(bus_b.reg_addr_o), 0);
    check("rst_wdata", 32'(bus_b.reg_wdata_o), 0);
    check("rst_strobes", 32'({bus_b.reg_write_o, bus_b.reg_read_o}), 0);
    check("rst_errs", 32'({bus_b.err_timeout_o, bus_b.err_overrun_o}), 0);
    idle(3);
    reset = 1'b0;
    idle(2);

    // Write with 1000-cycle gaps on the default-timeout instance
    w0 = wr_a; x0 = xf_a;
    send_byte(8'h57);
    idle(1000);
    send_byte(8'h10);
    idle(1000);
    send_byte(8'hA5);
    check("wr_strobe", 32'(bus_a.reg_write_o), 1);
    check("wr_addr", 32'(bus_a.reg_addr_o), 'h10);
    check("wr_wdata", 32'(bus_a.reg_wdata_o), 'hA5);
    idle(1);
    check("wr_resp_valid", 32'(bus_a.out_valid_o), 1);
    check("wr_resp_data", 32'(bus_a.out_data_o), 'h4B);
    idle(1);
    check("wr_resp_drop", 32'(bus_a.out_valid_o), 0);
    check("wr_count", 32'(wr_a - w0), 1);
    check("wr_xfer_count", 32'(xf_a - x0), 1);
    check("wr_xfer_data", 32'(last_a), 'h4B);

    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(2);

    // Read
    w0 = wr_b; r0 = rd_b; x0 = xf_b;
    rd_val = 8'h3C;
    send_byte(8'h52);
    send_byte(8'h22);
    check("rd_strobe", 32'(bus_b.reg_read_o), 1);
    check("rd_addr", 32'(bus_b.reg_addr_o), 'h22);
    idle(1);
    check("rd_wait_no_valid", 32'(bus_b.out_valid_o), 0);
    idle(1);
    check("rd_resp_valid", 32'(bus_b.out_valid_o), 1);
    check("rd_resp_data", 32'(bus_b.out_data_o), 'h3C);
    idle(2);
    check("rd_count", 32'(rd_b - r0), 1);
    check("rd_no_write", 32'(wr_b - w0), 0);
    check("rd_xfer", 32'(xf_b - x0), 1);

    // Unknown command, then a normal read
    w0 = wr_b; r0 = rd_b; x0 = xf_b;
    send_byte(8'h41);
    check("unk_valid", 32'(bus_b.out_valid_o), 1);
    check("unk_data", 32'(bus_b.out_data_o), 'h3F);
    idle(2);
    check("unk_no_strobes", 32'((wr_b - w0) + (rd_b - r0)), 0);
    check("unk_xfer", 32'(last_b), 'h3F);
    rd_val = 8'h77;
    send_byte(8'h52);
    send_byte(8'h01);
    check("unk_next_addr", 32'(bus_b.reg_addr_o), 'h01);
    idle(4);
    check("unk_next_resp", 32'(last_b), 'h77);
    check("unk_next_rd", 32'(rd_b - r0), 1);

    // Backpressure with an overrun byte during RESP
    check("ovr_clear_before", 32'(bus_b.err_overrun_o), 0);
    out_ready = 1'b0;
    x0 = xf_b;
    send_byte(8'h57);
    send_byte(8'h33);
    send_byte(8'h44);
    idle(1);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (!(bus_b.out_valid_o === 1'b1 && bus_b.out_data_o === 8'h4B)) stable = 1'b0;
      in_data  = 8'h99;
      in_valid = (i == 20);
      idle(1);
    end
    in_valid = 1'b0;
    check("bp_stable", 32'(stable), 1);
    check("bp_no_xfer", 32'(xf_b - x0), 0);
    check("ovr_set", 32'(bus_b.err_overrun_o), 1);
    check("ovr_addr_kept", 32'(bus_b.reg_addr_o), 'h33);
    out_ready = 1'b1;
    idle(1);
    check("bp_valid_drop", 32'(bus_b.out_valid_o), 0);
    idle(1);
    check("bp_one_xfer", 32'(xf_b - x0), 1);
    check("bp_xfer_data", 32'(last_b), 'h4B);

    // Timeout after a lone command byte
    w0 = wr_b; r0 = rd_b; x0 = xf_b; t0 = to_b;
    send_byte(8'h57);
    idle(99);
    check("to_not_early", 32'(bus_b.err_timeout_o), 0);
    idle(1);
    check("to_pulse", 32'(bus_b.err_timeout_o), 1);
    idle(1);
    check("to_pulse_end", 32'(bus_b.err_timeout_o), 0);
    check("to_no_resp", 32'(bus_b.out_valid_o), 0);
    check("to_count", 32'(to_b - t0), 1);
    check("to_no_activity", 32'((wr_b - w0) + (rd_b - r0) + (xf_b - x0)), 0);
    rd_val = 8'hC4;
    send_byte(8'h52);
    send_byte(8'h05);
    check("to_back_idle", 32'(bus_b.reg_read_o), 1);
    idle(4);
    check("to_back_resp", 32'(last_b), 'hC4);
    check("ovr_sticky", 32'(bus_b.err_overrun_o), 1);

    // Byte arriving exactly on the expiry edge
    t0 = to_b; w0 = wr_b;
    send_byte(8'h57);
    idle(99);
    send_byte(8'h10);
    check("edge_no_timeout", 32'(bus_b.err_timeout_o), 0);
    send_byte(8'h66);
    check("edge_write", 32'(bus_b.reg_write_o), 1);
    check("edge_addr", 32'(bus_b.reg_addr_o), 'h10);
    check("edge_wdata", 32'(bus_b.reg_wdata_o), 'h66);
    idle(3);
    check("edge_to_count", 32'(to_b - t0), 0);
    check("edge_wr_count", 32'(wr_b - w0), 1);

    // Asynchronous reset mid-command
    w0 = wr_b; r0 = rd_b;
    send_byte(8'h57);
    send_byte(8'h10);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_addr", 32'(bus_b.reg_addr_o), 0);
    check("mid_rst_outs", 32'({bus_b.out_valid_o, bus_b.out_data_o, bus_b.reg_wdata_o}), 0);
    check("mid_rst_flags", 32'({bus_b.reg_write_o, bus_b.reg_read_o,
                                bus_b.err_timeout_o, bus_b.err_overrun_o}), 0);
    idle(2);
    reset = 1'b0;
    idle(1);
    rd_val = 8'h5A;
    send_byte(8'h52);
    send_byte(8'h10);
    check("post_rst_read", 32'(bus_b.reg_read_o), 1);
    idle(4);
    check("post_rst_resp", 32'(last_b), 'h5A);
    check("post_rst_no_write", 32'(wr_b - w0), 0);
    check("post_rst_rd_count", 32'(rd_b - r0), 1);
    check("one_strobe_max", 32'(both_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of uart_rx: consumes its received-byte stream (data_o/valid_o).
- Decodes framed single-byte register read/write commands and drives a simple on-chip register bus.
- Emits one response byte per command into the write side of a fifo that feeds uart_tx.
- Gives the board a host-controlled register interface over the 115200-baud link.

Parameters:
- TIMEOUT_CYCLES, 1200000: maximum idle gap between bytes of one command (100 ms at 12 MHz); counter width is $clog2(TIMEOUT_CYCLES+1).
- CMD_WRITE, 8'h57 ("W"): write command byte.
- CMD_READ, 8'h52 ("R"): read command byte.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- in_data_i  input  8  received byte from uart_rx
- in_valid_i  input  1  single-cycle strobe: in_data_i is valid
- out_data_o  output  8  response byte to the tx fifo
- out_valid_o  output  1  response is valid; held until accepted
- out_ready_i  input  1  fifo write_ready; transfer occurs when out_valid_o && out_ready_i
- reg_addr_o  output  8  register address
- reg_wdata_o  output  8  register write data
- reg_write_o  output  1  single-cycle write strobe
- reg_read_o  output  1  single-cycle read strobe
- reg_rdata_i  input  8  read data; valid exactly 1 cycle after reg_read_o
- err_timeout_o  output  1  single-cycle pulse on command timeout
- err_overrun_o  output  1  sticky: byte arrived while a response was pending; cleared only by reset

Behaviour:
- Reset (async assert; deassert sampled on clock):
  - state = IDLE.
  - All outputs 0: out_data_o, out_valid_o, reg_addr_o, reg_wdata_o, both strobes, both error outputs.
  - Timeout counter = 0.
- States: IDLE, GET_ADDR, GET_DATA, DO_WRITE, DO_READ, WAIT_READ, RESP.
- IDLE, on in_valid_i:
  - CMD_WRITE or CMD_READ -> GET_ADDR; latch command kind.
  - Any other byte -> RESP with out_data_o = 8'h3F ("?").
- GET_ADDR, on in_valid_i:
  - Latch reg_addr_o.
  - Write command -> GET_DATA; read command -> DO_READ.
- GET_DATA, on in_valid_i: latch reg_wdata_o -> DO_WRITE.
- DO_WRITE: reg_write_o = 1 for exactly this cycle -> RESP with out_data_o = 8'h4B ("K").
- DO_READ: reg_read_o = 1 for exactly this cycle -> WAIT_READ.
- WAIT_READ: capture reg_rdata_i into out_data_o -> RESP.
- RESP:
  - out_valid_o = 1; out_data_o held stable.
  - On out_valid_o && out_ready_i: out_valid_o drops the next cycle and state -> IDLE.
  - Acceptance in the first RESP cycle is legal.
- Latency from the final command byte strobe (cycle N):
  - Write: reg_write_o at N+1; out_valid_o from N+2.
  - Read: reg_read_o at N+1; out_valid_o from N+3.
- Timeout:
  - Counter clears on every in_valid_i and increments each cycle in GET_ADDR and GET_DATA.
  - When it reaches TIMEOUT_CYCLES: -> IDLE, err_timeout_o pulses 1 cycle, no response, no register strobe.
  - A byte arriving in the same cycle as expiry wins: it is processed and there is no timeout.
  - Counter saturates; it never wraps.
- Overrun: in_valid_i during DO_WRITE, DO_READ, WAIT_READ or RESP:
  - The byte is dropped and err_overrun_o is set.
  - The current transaction completes normally.
- Register outputs: reg_addr_o and reg_wdata_o hold their last latched values between commands.
- At most one strobe (reg_write_o or reg_read_o) is active in any cycle.
- Reset mid-command: state and outputs return to reset values immediately; the partial command is discarded and no strobe is issued.

Decomposition:
- Shared package uart_cmd_pkg:
  - State enum.
  - Response constants RESP_OK = 8'h4B and RESP_ERR = 8'h3F.
  - Default CMD_WRITE and CMD_READ values.
- Sub-module: timeout_counter (saturating counter with clear, enable and expired outputs). It is reusable for inter-byte gap detection elsewhere.

Test Plan:
- Write: bytes 57,10,A5 with 1000-cycle gaps, out_ready_i = 1 -> reg_write_o one cycle with reg_addr_o = 10 and reg_wdata_o = A5; then out_data_o = 4B with one accepted transfer.
- Read: bytes 52,22 with reg_rdata_i = 3C in the cycle after reg_read_o -> exactly one reg_read_o with address 22; response byte 3C; no reg_write_o.
- Unknown command: byte 41 -> response 3F; no strobes; next command 52,01 is handled normally.
- Backpressure and overrun:
  - out_ready_i = 0 for 50 cycles during RESP -> out_valid_o and out_data_o stay stable; exactly one transfer once ready rises.
  - A byte injected during RESP -> err_overrun_o = 1 and the byte is ignored.
- Timeout: byte 57 then silence with TIMEOUT_CYCLES = 100 -> err_timeout_o pulses at cycle 100 after the byte; state is IDLE; no response.
  - Boundary: a byte arriving exactly at cycle 100 is accepted as the address and no timeout fires.
- Reset mid-command: 57,10 then reset asserted asynchronously between clock edges -> all outputs 0 immediately; after release, 52,10 produces a read with no stale write.
